// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
// Optional checksum stage is enabled with the IMEM_BOOT_CHECKSUM_EN macro.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHK   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a byte stream, LSB first, into 32-bit words.
// The word is presented combinationally alongside word_valid on the 4th byte.
module byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] sr_q,  sr_d;

    // New bytes enter at the top, so the first byte ends up in [7:0].
    always_comb begin
        idx_d = idx_q;
        sr_d  = sr_q;
        if (clr) begin
            idx_d = 2'd0;
            sr_d  = 32'd0;
        end else if (byte_valid) begin
            idx_d = idx_q + 2'd1;
            sr_d  = {byte_data, sr_q[31:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            sr_q  <= 32'd0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

    assign word_valid = byte_valid && !clr && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, sr_q[31:8]};

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into IMEM, then releases the core reset.
// Define IMEM_BOOT_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_e PAYLOAD_END = ST_CHK;
    logic [7:0] sum_q, sum_d;
`else
    localparam state_e PAYLOAD_END = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              done_q, done_d;

    logic        fire;
    logic        restart;
    logic        pk_valid;
    logic        pk_word_valid;
    logic [31:0] pk_word;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHK);
    assign fire     = in_valid && in_ready;
    assign restart  = start && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign pk_valid = fire && ((state_q == ST_HDR) || (state_q == ST_LOAD));

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        words_d      = words_q;
        n_d          = n_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (pk_word_valid) begin
                    n_d = pk_word[ADDR_W:0];
                    if ({1'b0, pk_word} > CAP) begin
                        state_d = ST_ERROR;
                    end else if (pk_word == 32'd0) begin
                        state_d = PAYLOAD_END;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (pk_valid) begin
                    sum_d = sum_q + in_data;
                end
`endif
                // The guard stops stray bytes after the last word from writing.
                if (pk_word_valid && (words_q != n_q)) begin
                    imem_we_d    = 1'b1;
                    imem_wdata_d = pk_word;
                    imem_addr_d  = words_q[ADDR_W-1:0];
                    words_d      = words_q + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    if ((words_q + 1'b1) == n_q) begin
                        state_d = ST_CHK;
                    end
`endif
                end
`ifndef IMEM_BOOT_CHECKSUM_EN
                // Enter DONE only after the final write cycle has gone out.
                if (words_q == n_q) begin
                    state_d = ST_DONE;
                end
`endif
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (fire) begin
                    state_d = (in_data == sum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_HDR;
                    words_d = '0;
                    n_d     = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            default: state_d = ST_HDR;
        endcase
        done_d = (state_q == ST_DONE) && !start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            words_q      <= '0;
            n_q          <= '0;
            done_q       <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            words_q      <= words_d;
            n_q          <= n_d;
            done_q       <= done_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign words_loaded = words_q;
    assign done         = done_q;
    assign core_rst_n   = done_q;
    assign error        = (state_q == ST_ERROR);

endmodule
